// File: rtl/lsq_mem_unit_pkg.sv
// Shared types for the LSQ-head memory unit: queue entry, CDB packet and FSM state codes.
package lsq_mem_unit_pkg;

  localparam int DATA_W = 32;
  localparam int ROB_W  = 4;

  localparam logic [ROB_W-1:0] ROB_NONE = '0;

  typedef struct packed {
    logic [ROB_W-1:0]  rob_entry;
    logic [DATA_W-1:0] address;
    logic [DATA_W-1:0] result;
    logic              load;
  } lsq_packet_t;

  typedef struct packed {
    logic [ROB_W-1:0]  dest_rob_entry;
    logic [DATA_W-1:0] result;
  } CDB_packet_t;

  typedef logic [2:0] mem_state_t;

  localparam mem_state_t S_IDLE     = 3'd0;
  localparam mem_state_t S_LD_REQ   = 3'd1;
  localparam mem_state_t S_LD_BCAST = 3'd2;
  localparam mem_state_t S_LD_DRAIN = 3'd3;
  localparam mem_state_t S_ST_REQ   = 3'd4;

endpackage

// File: rtl/lsq_mem_unit_req_hold.sv
// Registered dmem request holder: loads on start, keeps req/we/addr/wdata stable until dmem_ready.
module lsq_mem_unit_req_hold
  import lsq_mem_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              dmem_ready_i,
  output logic              req_o,
  output logic              we_o,
  output logic [DATA_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o
);

  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  always_comb begin
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (start_i) begin
      req_d   = 1'b1;
      we_d    = we_i;
      addr_d  = addr_i;
      wdata_d = wdata_i;
    end else if (req_q && dmem_ready_i) begin
      // Address/data stay latched after completion; only the request drops.
      req_d = 1'b0;
      we_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign req_o   = req_q;
  assign we_o    = we_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;

endmodule

// File: rtl/lsq_mem_unit.sv
// LSQ head consumer: issues one dmem access at a time, broadcasts load data on the CDB,
// and commits stores only when their ROB entry is at the ROB head.
module lsq_mem_unit
  import lsq_mem_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              lsq_empty,
  input  logic              lsq_head_ready,
  input  logic              lsq_head_load,
  input  lsq_packet_t       lsq_head,
  output logic              lsq_rd_en,
  input  logic [ROB_W-1:0]  rob_head_entry,
  input  logic              rob_head_valid,
  output logic              store_commit,
  input  logic              flush,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              cdb_req,
  input  logic              cdb_grant,
  output CDB_packet_t       cdb_out,
  output mem_state_t        dbg_state_o
);

  // Handshakes: a dmem access completes in the cycle dmem_req && dmem_ready (rdata valid
  // then for reads); a CDB broadcast completes in the cycle cdb_req && cdb_grant. Requests
  // are held with stable payload until they complete.

  mem_state_t        state_q, state_d;
  logic [ROB_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              head_ok, ld_go, st_go;
  logic [DATA_W-1:0] start_wdata;
  logic              unused_head_load;

  // lsq_head_load is the authoritative load flag; the packet copy is redundant.
  assign unused_head_load = lsq_head.load;

  assign head_ok = !lsq_empty && lsq_head_ready;
  assign ld_go   = (state_q == S_IDLE) && head_ok && lsq_head_load && !flush;
  assign st_go   = (state_q == S_IDLE) && head_ok && !lsq_head_load && rob_head_valid &&
                   (rob_head_entry == lsq_head.rob_entry);
  assign start_wdata = st_go ? lsq_head.result : '0;

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (ld_go) begin
          state_d = S_LD_REQ;
          tag_d   = lsq_head.rob_entry;
        end else if (st_go) begin
          state_d = S_ST_REQ;
          tag_d   = lsq_head.rob_entry;
        end
      end
      S_LD_REQ: begin
        if (dmem_ready) begin
          rdata_d = dmem_rdata;
          state_d = flush ? S_IDLE : S_LD_BCAST;
        end else if (flush) begin
          state_d = S_LD_DRAIN;
        end
      end
      // The access cannot be cancelled; wait it out and drop the data.
      S_LD_DRAIN: if (dmem_ready) state_d = S_IDLE;
      S_LD_BCAST: if (cdb_grant || flush) state_d = S_IDLE;
      S_ST_REQ:   if (dmem_ready) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tag_q   <= ROB_NONE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      rdata_q <= rdata_d;
    end
  end

  lsq_mem_unit_req_hold u_hold (
    .clk          (clk),
    .reset        (reset),
    .start_i      (ld_go || st_go),
    .we_i         (st_go),
    .addr_i       (lsq_head.address),
    .wdata_i      (start_wdata),
    .dmem_ready_i (dmem_ready),
    .req_o        (dmem_req),
    .we_o         (dmem_we),
    .addr_o       (dmem_addr),
    .wdata_o      (dmem_wdata)
  );

  assign lsq_rd_en    = ((state_q == S_LD_REQ) || (state_q == S_ST_REQ)) && dmem_ready && !lsq_empty;
  assign store_commit = (state_q == S_ST_REQ) && dmem_ready;
  assign cdb_req      = (state_q == S_LD_BCAST);
  assign cdb_out      = cdb_req ? CDB_packet_t'{dest_rob_entry: tag_q, result: rdata_q} : '0;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_lsq_mem_unit.sv
// Bench for lsq_mem_unit: IDLE decision table, transaction-level scoreboard with random
// loads/stores, and hand sequences for flush and reset corner cases.
module tb_lsq_mem_unit;
  import lsq_mem_unit_pkg::*;

  localparam int ACC_W = 16 + 1 + 32 + 32;
  localparam int CDB_W = 16 + 4 + 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              lsq_empty, lsq_head_ready, lsq_head_load;
  lsq_packet_t       lsq_head;
  logic              lsq_rd_en;
  logic [ROB_W-1:0]  rob_head_entry;
  logic              rob_head_valid, store_commit, flush;
  logic              dmem_req, dmem_we, dmem_ready;
  logic [DATA_W-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic              cdb_req, cdb_grant;
  CDB_packet_t       cdb_out;
  mem_state_t        dbg_state;

  lsq_mem_unit dut (
    .clk(clk), .reset(reset), .lsq_empty(lsq_empty), .lsq_head_ready(lsq_head_ready),
    .lsq_head_load(lsq_head_load), .lsq_head(lsq_head), .lsq_rd_en(lsq_rd_en),
    .rob_head_entry(rob_head_entry), .rob_head_valid(rob_head_valid),
    .store_commit(store_commit), .flush(flush), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .cdb_req(cdb_req), .cdb_grant(cdb_grant), .cdb_out(cdb_out),
    .dbg_state_o(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    lsq_empty      = 1'b1;
    lsq_head_ready = 1'b0;
    lsq_head_load  = 1'b0;
    lsq_head       = '0;
    rob_head_valid = 1'b0;
    rob_head_entry = '0;
    flush          = 1'b0;
    dmem_ready     = 1'b0;
    dmem_rdata     = '0;
    cdb_grant      = 1'b0;
  endtask

  task automatic present(input logic ld, input logic [3:0] tag, input logic [31:0] addr,
                         input logic [31:0] wd);
    lsq_empty      = 1'b0;
    lsq_head_ready = 1'b1;
    lsq_head_load  = ld;
    lsq_head       = '{rob_entry: tag, address: addr, result: wd, load: ld};
  endtask

  // scoreboard: expected dmem accesses {cycle, we, addr, wdata} and CDB broadcasts {cycle, tag, data}
  logic [ACC_W-1:0] exp_acc_q[$];
  logic [CDB_W-1:0] exp_cdb_q[$];
  int  exp_pops = 0, exp_commits = 0, obs_pops = 0, obs_commits = 0;
  bit  sb_en = 1'b0;

  logic        p_req = 1'b0, p_rdy = 1'b0, p_rst = 1'b1, p_flush = 1'b0, p_we = 1'b0;
  logic        p_cdb = 1'b0, p_gnt = 1'b0;
  logic [31:0] p_addr = '0, p_wdata = '0;
  CDB_packet_t p_out = '0;

  always @(negedge clk) begin
    logic [ACC_W-1:0] a_obs;
    logic [CDB_W-1:0] c_obs;
    if (p_req && !p_rdy && !p_rst)
      check("req_hold", 128'({dmem_req, dmem_we, dmem_addr, dmem_wdata}),
            128'({1'b1, p_we, p_addr, p_wdata}));
    if (p_cdb && !p_gnt && !p_flush && !p_rst)
      check("cdb_hold", 128'({cdb_req, cdb_out}), 128'({1'b1, p_out}));
    if (lsq_rd_en) check("pop_nonempty", 128'(lsq_empty), 128'(0));
    if (store_commit)
      check("commit_pop_write", 128'({lsq_rd_en, dmem_we, dmem_ready}), 128'(3'b111));
    if (sb_en && !reset) begin
      if (dmem_req && dmem_ready) begin
        a_obs = {cyc[15:0], dmem_we, dmem_addr, (dmem_we ? dmem_wdata : 32'h0)};
        if (exp_acc_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL dmem_access: got %0h expected none", a_obs);
        end else check("dmem_access", 128'(a_obs), 128'(exp_acc_q.pop_front()));
      end
      if (cdb_req && cdb_grant) begin
        c_obs = {cyc[15:0], cdb_out};
        if (exp_cdb_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL cdb_bcast: got %0h expected none", c_obs);
        end else check("cdb_bcast", 128'(c_obs), 128'(exp_cdb_q.pop_front()));
      end
      if (lsq_rd_en) obs_pops <= obs_pops + 1;
      if (store_commit) obs_commits <= obs_commits + 1;
    end
    p_req <= dmem_req;   p_rdy <= dmem_ready; p_rst <= reset; p_flush <= flush;
    p_we <= dmem_we;     p_addr <= dmem_addr; p_wdata <= dmem_wdata;
    p_cdb <= cdb_req;    p_gnt <= cdb_grant;  p_out <= cdb_out;
  end

  // One transaction with a reactive memory (stall cycles) and arbiter (grant delay).
  // Store ROB head mismatches for robdel cycles. Expected event cycles follow from
  // detection cycle d: load access d+1+stall, broadcast one cycle later plus grant delay;
  // store access d+robdel+1+stall.
  task automatic run_txn(input logic ld, input logic [3:0] tag, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rdv,
                         input int stall, input int gdel, input int robdel);
    int d, sc, gc;
    bit done, popped;
    tick();
    d = cyc;
    present(ld, tag, addr, wd);
    if (ld) begin
      exp_acc_q.push_back({16'(d + 1 + stall), 1'b0, addr, 32'h0});
      exp_cdb_q.push_back({16'(d + 2 + stall + gdel), tag, rdv});
      rob_head_valid = 1'($urandom_range(0, 1));
      rob_head_entry = 4'($urandom_range(0, 15));
    end else begin
      exp_acc_q.push_back({16'(d + robdel + 1 + stall), 1'b1, addr, wd});
      exp_commits++;
      rob_head_valid = 1'b1;
      rob_head_entry = (robdel > 0) ? (tag ^ 4'h8) : tag;
    end
    exp_pops++;
    sc = 0; gc = 0; done = 1'b0; popped = 1'b0;
    for (int k = 1; k < 200 && !done; k++) begin
      tick();
      if (!ld) rob_head_entry = (k >= robdel) ? tag : (tag ^ 4'h8);
      lsq_empty  = popped;
      dmem_ready = 1'b0;
      cdb_grant  = 1'b0;
      dmem_rdata = $urandom;
      if (dmem_req) begin
        if (sc == stall) begin
          dmem_ready = 1'b1;
          dmem_rdata = rdv;
        end
        sc++;
      end
      if (cdb_req) begin
        if (gc == gdel) cdb_grant = 1'b1;
        gc++;
      end
      @(negedge clk);
      if (lsq_rd_en) popped = 1'b1;
      if (ld ? (cdb_req && cdb_grant) : store_commit) done = 1'b1;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL txn_timeout: tag %0d got no completion expected completion", tag);
      tick(); idle_inputs(); reset = 1'b1;
      tick(); reset = 1'b0;
      exp_acc_q.delete(); exp_cdb_q.delete();
      exp_pops = obs_pops; exp_commits = obs_commits;
    end
    tick();
    idle_inputs();
  endtask

  typedef struct {
    logic        empty, rdy, ld, fl, rv;
    logic [3:0]  rob, tag;
    logic [31:0] addr;
    logic        exp_req, exp_we;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    tick(); tick();
    @(negedge clk);
    check("rst_ctrl", 128'({dmem_req, dmem_we, lsq_rd_en, store_commit, cdb_req}), 128'(0));
    check("rst_cdb_out", 128'(cdb_out), 128'(0));
    check("rst_addr_wdata", 128'({dmem_addr, dmem_wdata}), 128'(0));
    check("rst_state", 128'(dbg_state), 128'(S_IDLE));
    tick();
    reset = 1'b0;

    // IDLE launch decision: {empty, head_ready, load, flush, rob_valid, rob_head, tag, addr} -> {req, we}
    vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd3, 32'h40,  1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd3, 32'h44,  1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd3, 32'h48,  1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd3, 32'h4c,  1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 4'd5, 32'h80,  1'b1, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd4, 4'd5, 32'h84,  1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 4'd5, 32'h88,  1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd5, 4'd5, 32'h8c,  1'b1, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 4'd5, 32'h90,  1'b0, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd9, 4'd9, 32'h94,  1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      tick();
      present(vecs[i].ld, vecs[i].tag, vecs[i].addr, 32'h1234_0000 + 32'(i));
      lsq_empty      = vecs[i].empty;
      lsq_head_ready = vecs[i].rdy;
      flush          = vecs[i].fl;
      rob_head_valid = vecs[i].rv;
      rob_head_entry = vecs[i].rob;
      tick();
      idle_inputs();
      @(negedge clk);
      check($sformatf("vec%0d_req_we", i), 128'({dmem_req, dmem_we}),
            128'({vecs[i].exp_req, vecs[i].exp_we}));
      check($sformatf("vec%0d_addr", i), 128'(dmem_addr),
            128'(vecs[i].exp_req ? vecs[i].addr : 32'h0));
      check($sformatf("vec%0d_wdata", i), 128'(dmem_wdata),
            128'(vecs[i].exp_we ? (32'h1234_0000 + 32'(i)) : 32'h0));
      tick(); reset = 1'b1;
      tick(); reset = 1'b0;
    end

    // scoreboarded transactions: directed corner cases, then random mix
    sb_en = 1'b1;
    run_txn(1'b1, 4'd3, 32'h40, 32'h0, 32'hDEADBEEF, 0, 0, 0);
    run_txn(1'b0, 4'd5, 32'h80, 32'h1234, 32'h0, 0, 0, 3);
    run_txn(1'b1, 4'd6, 32'hC0, 32'h0, 32'h0BAD_F00D, 4, 0, 0);
    run_txn(1'b1, 4'd7, 32'hC4, 32'h0, 32'h1357_9BDF, 0, 3, 0);
    run_txn(1'b0, 4'd8, 32'hC8, 32'hA5A5_5A5A, 32'h0, 2, 0, 1);
    for (int t = 0; t < 40; t++) begin
      logic rl;
      rl = 1'($urandom_range(0, 1));
      run_txn(rl, 4'($urandom_range(1, 15)), $urandom, $urandom, $urandom,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    tick(); tick();
    check("acc_q_drained", 128'(exp_acc_q.size()), 128'(0));
    check("cdb_q_drained", 128'(exp_cdb_q.size()), 128'(0));
    check("pop_count", 128'(obs_pops), 128'(exp_pops));
    check("commit_count", 128'(obs_commits), 128'(exp_commits));
    sb_en = 1'b0;

    // flush while load stalls: drain, no pop, no broadcast
    tick(); present(1'b1, 4'd7, 32'h100, 32'h0);
    tick(); @(negedge clk);
    check("drain_ldreq", 128'({dbg_state, dmem_req}), 128'({S_LD_REQ, 1'b1}));
    tick(); flush = 1'b1;
    @(negedge clk); check("drain_flush_nopop", 128'(lsq_rd_en), 128'(0));
    tick(); flush = 1'b0; lsq_empty = 1'b1;
    @(negedge clk);
    check("drain_state", 128'({dbg_state, dmem_req, dmem_addr}), 128'({S_LD_DRAIN, 1'b1, 32'h100}));
    tick(); dmem_ready = 1'b1; dmem_rdata = 32'h7777_7777;
    @(negedge clk); check("drain_ready", 128'({lsq_rd_en, cdb_req}), 128'(0));
    tick(); dmem_ready = 1'b0;
    @(negedge clk);
    check("drain_done", 128'({dbg_state, dmem_req, cdb_req}), 128'({S_IDLE, 2'b00}));
    tick(); @(negedge clk); check("drain_no_bcast", 128'(cdb_req), 128'(0));

    // flush coinciding with dmem_ready in LD_REQ: pop happens, no broadcast
    tick(); idle_inputs(); present(1'b1, 4'd9, 32'h200, 32'h0);
    tick(); dmem_ready = 1'b1; flush = 1'b1; dmem_rdata = 32'h2222_0000;
    @(negedge clk); check("flush_rdy_pop", 128'(lsq_rd_en), 128'(1));
    tick(); idle_inputs();
    @(negedge clk); check("flush_rdy_idle", 128'({dbg_state, cdb_req}), 128'({S_IDLE, 1'b0}));

    // flush in LD_BCAST without grant: broadcast abandoned
    tick(); present(1'b1, 4'd10, 32'h300, 32'h0);
    tick(); dmem_ready = 1'b1; dmem_rdata = 32'h3333_0000;
    tick(); idle_inputs(); flush = 1'b1;
    @(negedge clk); check("bcast_flush_req", 128'({cdb_req, cdb_out}), 128'({1'b1, 4'd10, 32'h3333_0000}));
    tick(); flush = 1'b0;
    @(negedge clk); check("bcast_flush_idle", 128'({dbg_state, cdb_req}), 128'({S_IDLE, 1'b0}));

    // flush during ST_REQ is ignored: commit still happens
    tick(); present(1'b0, 4'd2, 32'h400, 32'h55AA); rob_head_valid = 1'b1; rob_head_entry = 4'd2;
    tick(); flush = 1'b1; dmem_ready = 1'b1;
    @(negedge clk);
    check("st_flush_commit", 128'({store_commit, lsq_rd_en, dmem_we, dmem_addr, dmem_wdata}),
          128'({3'b111, 32'h400, 32'h55AA}));
    tick(); idle_inputs();
    @(negedge clk); check("st_flush_idle", 128'({dbg_state, dmem_req}), 128'({S_IDLE, 1'b0}));

    // reset asserted in LD_BCAST: everything back to zero next cycle
    tick(); present(1'b1, 4'd12, 32'h500, 32'h0);
    tick(); dmem_ready = 1'b1; dmem_rdata = 32'hCAFEF00D;
    tick(); idle_inputs(); reset = 1'b1;
    @(negedge clk); check("rst_bcast_pre", 128'({cdb_req, cdb_out}), 128'({1'b1, 4'd12, 32'hCAFEF00D}));
    tick(); reset = 1'b0;
    @(negedge clk);
    check("rst_bcast_ctrl", 128'({dmem_req, dmem_we, lsq_rd_en, store_commit, cdb_req}), 128'(0));
    check("rst_bcast_out", 128'({dbg_state, cdb_out}), 128'({S_IDLE, 36'h0}));

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsq_mem_unit.md
Name: lsq_mem_unit

Overview:
- Consumer at the head of the load/store queue. Pops ready entries and performs the data-memory access over a req/ready handshake.
- Load data is broadcast on the common data bus through a request/grant arbiter.
- Stores are written to memory only when their ROB entry is at the ROB head; the unit then signals the ROB to retire that entry.
- Sits between the lsq, dmem, the CDB arbiter and the ROB.

Parameters:
- DATA_W, 32, width of address, store data and load data.
- ROB_W, 4, ROB tag width. Tag 0 means "no tag".

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- lsq_empty  in  1  lsq holds no entries
- lsq_head_ready  in  1  head address valid and store data resolved
- lsq_head_load  in  1  head entry is a load
- lsq_head  in  lsq_packet_t  head entry (ROB_entry, address, result, load)
- lsq_rd_en  out  1  one-cycle pop of the lsq head
- rob_head_entry  in  ROB_W  tag at the ROB head
- rob_head_valid  in  1  ROB non-empty
- store_commit  out  1  one-cycle pulse; ROB retires its head store
- flush  in  1  squash speculative loads
- dmem_req  out  1  memory request valid
- dmem_we  out  1  1 = write
- dmem_addr  out  DATA_W  access address
- dmem_wdata  out  DATA_W  store data
- dmem_ready  in  1  request accepted/completed this cycle; rdata valid if read
- dmem_rdata  in  DATA_W  load data
- cdb_req  out  1  request CDB slot
- cdb_grant  in  1  arbiter grant, same cycle as cdb_req
- cdb_out  out  CDB_packet_t  {dest_ROB_entry, result}

Behaviour:
- State machine states: IDLE, LD_REQ, LD_BCAST, LD_DRAIN, ST_REQ. All outputs are Moore, except the pops and commit, which are qualified by dmem_ready.
- Reset: state IDLE. Registers clear: latched tag, address, wdata, rdata.
  - Outputs at reset: dmem_req=0, dmem_we=0, lsq_rd_en=0, store_commit=0, cdb_req=0, cdb_out=0.
- IDLE:
  - If !lsq_empty && lsq_head_ready && lsq_head_load && !flush: latch ROB_entry and address, go to LD_REQ.
  - Else if !lsq_empty && lsq_head_ready && !lsq_head_load && rob_head_valid && rob_head_entry==lsq_head.ROB_entry: latch ROB_entry, address and result, go to ST_REQ.
  - Otherwise stay in IDLE.
- LD_REQ:
  - Drive dmem_req=1, dmem_we=0, dmem_addr=latched address. Hold these stable until dmem_ready.
  - On dmem_ready: capture dmem_rdata and pulse lsq_rd_en for that cycle. Go to LD_BCAST, or to IDLE if flush is high in that cycle.
  - flush while still waiting: go to LD_DRAIN. The memory transaction cannot be cancelled.
- LD_DRAIN: keep dmem_req held; on dmem_ready, discard the data, do not pop the lsq, go to IDLE. After a flush the lsq itself is reset by its owner.
- LD_BCAST:
  - Drive cdb_req=1 and cdb_out={latched tag, captured rdata}. Hold until cdb_grant, then go to IDLE.
  - flush without grant: go to IDLE with no broadcast. Grant and flush in the same cycle: the broadcast counts, then go to IDLE.
- ST_REQ:
  - Drive dmem_req=1, dmem_we=1, addr and wdata from the latches, held stable.
  - On dmem_ready: pulse lsq_rd_en and store_commit in the same cycle, go to IDLE.
  - flush is ignored, because the store is non-speculative at the ROB head.
- At most one outstanding access. lsq_rd_en never asserts when lsq_empty.
- Load latency with zero-wait dmem and immediate grant: IDLE (detect) -> LD_REQ (ready) -> LD_BCAST (grant) -> IDLE. CDB result appears 2 cycles after detection.
- Store latency: detect -> ST_REQ -> commit pulse 1 cycle after detection.
- Mid-operation reset returns to IDLE next edge. Any in-flight dmem request is dropped.

Decomposition:
- Shared package (structs.svh): lsq_packet_t, CDB_packet_t, mem_state_t enum, ROB_NONE=0.
- Natural sub-module: mem_req_hold, a registered req/addr/wdata/we holder that keeps the request stable until dmem_ready. The FSM stays in lsq_mem_unit.

Test Plan:
- Load, zero-wait dmem, grant immediate: head {ROB 3, addr 0x40, load}, rdata 0xDEADBEEF -> dmem_req 1 cycle, lsq_rd_en 1 pulse, cdb_out {3, 0xDEADBEEF} 2 cycles after detect.
- Store gated by ROB: head {ROB 5, addr 0x80, result 0x1234, store}, rob_head_entry=4 for 3 cycles, then 5 -> no dmem_req until tag matches; then dmem_we=1, addr 0x80, wdata 0x1234; store_commit and lsq_rd_en pulse together on dmem_ready.
- dmem stalls 4 cycles on load -> dmem_req and addr stable for all 5 cycles; single pop.
- CDB grant withheld 3 cycles -> cdb_req and cdb_out held constant, one broadcast only.
- flush during LD_REQ stall -> LD_DRAIN; on dmem_ready there is no pop, no cdb_req, return to IDLE. A flush during ST_REQ still commits.
- reset asserted in LD_BCAST -> next cycle all outputs 0, state IDLE.
